lcd_frame_capture: RTL and testbench

//  Sink end of the LCD panel interface driven by cnn_top (oLcdHSync/oLcdVSync/oLcdDe/oLcdR/G/B).

---
 rtl/cnn_lcd_pkg.sv | 36 +++
 rtl/lcd_crc16.sv | 24 ++
 rtl/lcd_frame_capture.sv | 194 +++++++++++++++++++
 tb/tb_lcd_frame_capture.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_lcd_pkg.sv
// Shared definitions for the LCD capture path: FSM encoding, panel geometry
// defaults, RGB565 field positions and the CRC-16-CCITT step function.
package cnn_lcd_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_LINE = 2'd1;
  localparam logic [1:0] ST_LINE      = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  localparam int unsigned H_ACTIVE_DEF = 480;
  localparam int unsigned V_ACTIVE_DEF = 272;

  localparam int unsigned RGB_R_MSB = 15;
  localparam int unsigned RGB_R_LSB = 11;
  localparam int unsigned RGB_G_MSB = 10;
  localparam int unsigned RGB_G_LSB = 5;
  localparam int unsigned RGB_B_MSB = 4;
  localparam int unsigned RGB_B_LSB = 0;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  // One 16-bit word folded into the CRC, MSB first, unreflected.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < 16; i++) begin
      fb = c[15] ^ data[15 - i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/lcd_crc16.sv
// Data-parallel CRC-16-CCITT accumulator: one 16-bit word per enabled cycle,
// iInit reloads the seed and takes priority over iEn.
module lcd_crc16
  import cnn_lcd_pkg::*;
(
  input  logic        iClk,
  input  logic        iRsn,
  input  logic        iInit,
  input  logic        iEn,
  input  logic [15:0] iData,
  output logic [15:0] oCrc
);

  logic [15:0] crc_q;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn)      crc_q <= '0;
    else if (iInit) crc_q <= CRC_SEED;
    else if (iEn)   crc_q <= crc16_step(crc_q, iData);
  end

  assign oCrc = crc_q;

endmodule

// File: rtl/lcd_frame_capture.sv
// LCD sync/DE sink: rebuilds frames, writes active pixels in raster order and
// flags geometry errors. Frame CRC is built only when LCD_CRC_EN is defined.
module lcd_frame_capture
  import cnn_lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = 17,
  parameter bit          SYNC_LOW = 1'b1
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iPixEn,
  input  logic              iArm,
  input  logic              iHSync,
  input  logic              iVSync,
  input  logic              iDe,
  input  logic [15:0]       iRgb,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [15:0]       oWrData,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic              oErr,
  output logic [15:0]       oFrameCnt,
  output logic [15:0]       oCrc
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     H_X = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     V_Y = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_A = ADDR_W'(H_ACTIVE);

  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              err_q, err_d;
  logic              restart_q, restart_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              hs_q, vs_q, de_q;
  logic              hs_act, vs_act;
  logic              hs_rise, vs_rise, de_rise;
  logic              frame_start;

  assign hs_act  = SYNC_LOW ? ~iHSync : iHSync;
  assign vs_act  = SYNC_LOW ? ~iVSync : iVSync;
  assign hs_rise = iPixEn & hs_act & ~hs_q;
  assign vs_rise = iPixEn & vs_act & ~vs_q;
  assign de_rise = iPixEn & iDe & ~de_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    base_d      = base_q;
    err_d       = err_q;
    restart_d   = restart_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (vs_rise && iArm) frame_start = 1'b1;
      end
      ST_WAIT_LINE: begin
        if (y_q == V_Y) begin
          state_d = ST_DONE;
        end else if (vs_rise) begin
          err_d     = 1'b1;
          restart_d = iArm;
          state_d   = ST_DONE;
        end else if (de_rise) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = iRgb;
          x_d       = {{(XW-1){1'b0}}, 1'b1};
          addr_d    = addr_q + 1'b1;
          state_d   = ST_LINE;
        end
      end
      ST_LINE: begin
        if (vs_rise) begin
          err_d     = 1'b1;
          restart_d = iArm;
          state_d   = ST_DONE;
        end else if (iPixEn && iDe) begin
          if (x_q < H_X) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = iRgb;
            x_d       = x_q + 1'b1;
            addr_d    = addr_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (iPixEn) begin
          // Short lines leave addr behind; re-anchor to the next line start.
          if (x_q != H_X) err_d = 1'b1;
          base_d  = base_q + H_A;
          addr_d  = base_q + H_A;
          y_d     = y_q + 1'b1;
          x_d     = '0;
          state_d = ST_WAIT_LINE;
        end
      end
      default: begin
        cnt_d     = cnt_q + 1'b1;
        restart_d = 1'b0;
        state_d   = ST_IDLE;
        if (restart_q || (vs_rise && iArm)) frame_start = 1'b1;
      end
    endcase

    if ((state_q == ST_WAIT_LINE || state_q == ST_LINE) && hs_rise && iDe) err_d = 1'b1;

    if (frame_start) begin
      state_d   = ST_WAIT_LINE;
      x_d       = '0;
      y_d       = '0;
      addr_d    = '0;
      base_d    = '0;
      err_d     = 1'b0;
      restart_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      base_q    <= '0;
      err_q     <= 1'b0;
      restart_q <= 1'b0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      err_q     <= err_d;
      restart_q <= restart_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (iPixEn) begin
        hs_q <= hs_act;
        vs_q <= vs_act;
        de_q <= iDe;
      end
    end
  end

  assign oWrEn      = wr_en_q;
  assign oWrAddr    = wr_addr_q;
  assign oWrData    = wr_data_q;
  assign oBusy      = (state_q != ST_IDLE);
  assign oFrameDone = (state_q == ST_DONE);
  assign oErr       = err_q;
  assign oFrameCnt  = cnt_q;

`ifdef LCD_CRC_EN
  lcd_crc16 u_crc (
    .iClk  (iClk),
    .iRsn  (iRsn),
    .iInit (frame_start),
    .iEn   (wr_en_d),
    .iData (iRgb),
    .oCrc  (oCrc)
  );
`else
  assign oCrc = '0;
`endif

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture on a reduced 8x4 panel, pixel enable
// every second clock, active-low syncs.
module tb_lcd_frame_capture;

  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst_n, pix_en, arm, hs, vs, de;
  logic [15:0]   rgb;
  logic          wr_en, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data, fcnt, crc;

  always #5 clk = ~clk;

  lcd_frame_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW),
    .SYNC_LOW (1'b1)
  ) dut (
    .iClk       (clk),
    .iRsn       (rst_n),
    .iPixEn     (pix_en),
    .iArm       (arm),
    .iHSync     (hs),
    .iVSync     (vs),
    .iDe        (de),
    .iRgb       (rgb),
    .oWrEn      (wr_en),
    .oWrAddr    (wr_addr),
    .oWrData    (wr_data),
    .oBusy      (busy),
    .oFrameDone (done),
    .oErr       (err),
    .oFrameCnt  (fcnt),
    .oCrc       (crc)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic        done_err_q[$];
  logic [15:0] done_crc_q[$];
  logic [15:0] crc_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC-16-CCITT over one pixel word.
  function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (wr_en) got_q.push_back({{(16-AW){1'b0}}, wr_addr, wr_data});
    if (done) begin
      done_err_q.push_back(err);
      done_crc_q.push_back(crc);
    end
  end

  task automatic pix(input logic h, input logic v, input logic d, input logic [15:0] px);
    @(negedge clk);
    hs = h; vs = v; de = d; rgb = px; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) pix(1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic vsync();
    pix(1'b1, 1'b0, 1'b0, 16'h0);
    pix(1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  // One line: hsync pulse, back porch, npix active pixels (data = y*H+i), front porch.
  task automatic line(input int y, input int npix, input bit capt);
    logic [15:0] px;
    pix(1'b0, 1'b1, 1'b0, 16'h0);
    pix(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < npix; i++) begin
      px = 16'(y * H + i);
      pix(1'b1, 1'b1, 1'b1, px);
      if (capt && i < H) begin
        exp_q.push_back({16'(y * H + i), px});
        crc_m = crc_ref(crc_m, px);
      end
    end
    pix(1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic full_frame(input bit capt);
    for (int y = 0; y < V; y++) line(y, H, capt);
  endtask

  task automatic compare(input string tag, input int exp_done, input logic exp_err);
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_ndone"}, done_err_q.size(), exp_done);
    if (done_err_q.size() > 0) begin
      check({tag, "_err"}, done_err_q[$], exp_err);
`ifdef LCD_CRC_EN
      check({tag, "_crc"}, done_crc_q[$], crc_m);
`else
      check({tag, "_crc"}, done_crc_q[$], 16'h0000);
`endif
    end
    got_q.delete();
    exp_q.delete();
    done_err_q.delete();
    done_crc_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, {wr_en, busy, done, err}, 4'b0000);
    check({tag, "_addr"}, wr_addr, '0);
    check({tag, "_data"}, wr_data, 16'h0);
    check({tag, "_fcnt"}, fcnt, 16'h0);
    check({tag, "_crc"}, crc, 16'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; arm = 1'b0;
    hs = 1'b1; vs = 1'b1; de = 1'b0; rgb = 16'h0; crc_m = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Clean frame, data equals address.
    arm = 1'b1;
    vsync();
    crc_m = 16'hFFFF;
    full_frame(1'b1);
    idle(3);
    compare("t1", 1, 1'b0);
    check("t1_fcnt", fcnt, 16'd1);
    check("t1_busy", busy, 1'b0);

    // Line 1 short by one pixel: line 2 realigned to address 16.
    vsync();
    crc_m = 16'hFFFF;
    line(0, H, 1'b1); line(1, H - 1, 1'b1); line(2, H, 1'b1); line(3, H, 1'b1);
    idle(3);
    compare("t2", 1, 1'b1);
    check("t2_fcnt", fcnt, 16'd2);

    // Line 2 one pixel too long: the extra pixel is dropped.
    vsync();
    crc_m = 16'hFFFF;
    line(0, H, 1'b1); line(1, H, 1'b1); line(2, H + 1, 1'b1); line(3, H, 1'b1);
    idle(3);
    compare("t2b", 1, 1'b1);
    check("t2b_fcnt", fcnt, 16'd3);

    // VSync after two lines closes the frame with error and restarts at address 0.
    vsync();
    crc_m = 16'hFFFF;
    line(0, H, 1'b1); line(1, H, 1'b1);
    vsync();
    crc_m = 16'hFFFF;
    full_frame(1'b1);
    idle(3);
    check("t3_ndone_all", done_err_q.size(), 2);
    if (done_err_q.size() == 2) begin
      check("t3_short_err", done_err_q.pop_front(), 1'b1);
      void'(done_crc_q.pop_front());
    end
    compare("t3", 1, 1'b0);
    check("t3_fcnt", fcnt, 16'd5);

    // Not armed at VSync: arming mid-frame captures nothing.
    arm = 1'b0;
    vsync();
    line(0, H, 1'b0); line(1, H, 1'b0);
    arm = 1'b1;
    line(2, H, 1'b0); line(3, H, 1'b0);
    idle(3);
    compare("t4a", 0, 1'b0);
    check("t4a_busy", busy, 1'b0);

    // Disarm mid-frame: frame completes, then no further capture.
    vsync();
    crc_m = 16'hFFFF;
    line(0, H, 1'b1); line(1, H, 1'b1);
    arm = 1'b0;
    line(2, H, 1'b1); line(3, H, 1'b1);
    idle(3);
    compare("t4b", 1, 1'b0);
    check("t4b_fcnt", fcnt, 16'd6);
    vsync();
    line(0, H, 1'b0);
    idle(2);
    compare("t4c", 0, 1'b0);
    check("t4c_busy", busy, 1'b0);

    // Reset mid-line: outputs clear asynchronously, no frame done.
    arm = 1'b1;
    vsync();
    line(0, H, 1'b1);
    pix(1'b0, 1'b1, 1'b0, 16'h0);
    pix(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      pix(1'b1, 1'b1, 1'b1, 16'(H + i));
      exp_q.push_back({16'(H + i), 16'(H + i)});
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("t5_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    compare("t5a", 0, 1'b0);
    vsync();
    crc_m = 16'hFFFF;
    full_frame(1'b1);
    idle(3);
    compare("t5b", 1, 1'b0);
    check("t5b_fcnt", fcnt, 16'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
